// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end with a DEPTH-entry queue.
//
// Issues sequential word-aligned fetches to an icache over a req/gnt
// handshake, tracks up to MAX_OUTST granted-but-unanswered requests, and
// queues the in-order responses with their PCs for decode. An EXE redirect
// empties the queue, reloads the fetch PC and drains in-flight responses.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   reset_adr_i                boot PC, taken in the cycle after reset release
//   icache_req_o/adr_o         fetch request and its word address (0 when idle)
//   icache_gnt_i               request accepted this cycle
//   icache_rvalid_i/instr_i    in-order response
//   flush_v_i, pc_data_q_i     redirect and its target PC
//   dec_ready_i                decode consumes the head entry this cycle
//   instr_v_q_o/instr_q_o/pc_q_o  head entry valid, instruction, PC
module ifetch_queue #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] reset_adr_i,
  output logic            icache_req_o,
  output logic [XLEN-1:0] icache_adr_o,
  input  logic            icache_gnt_i,
  input  logic            icache_rvalid_i,
  input  logic [31:0]     icache_instr_i,
  input  logic            flush_v_i,
  input  logic [XLEN-1:0] pc_data_q_i,
  input  logic            dec_ready_i,
  output logic            instr_v_q_o,
  output logic [31:0]     instr_q_o,
  output logic [XLEN-1:0] pc_q_o
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [OW-1:0]   r_outst;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [31:0]     r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];

  logic            w_flush;
  logic            w_credit_ok;
  logic            w_req;
  logic            w_gnt;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic [OW-1:0]   w_outst_nxt;
  logic [31:0]     w_fill;

  // A redirect while still in BOOT has no fetch stream to act on.
  assign w_flush = flush_v_i && (r_state != S_BOOT);

  // Credit rule: every granted request already owns a queue slot, so a
  // response can always be pushed without checking for space.
  assign w_fill      = 32'(r_count) + 32'(r_outst);
  assign w_credit_ok = (w_fill < 32'(DEPTH)) && (32'(r_outst) < 32'(MAX_OUTST));
  assign w_req       = (r_state == S_RUN) && !flush_v_i && w_credit_ok;
  assign w_gnt       = w_req && icache_gnt_i;

  // Responses with nothing outstanding are stale (e.g. across reset) and ignored.
  assign w_rsp  = icache_rvalid_i && (r_outst != '0);
  assign w_push = w_rsp && (r_state == S_RUN) && !w_flush;
  assign w_pop  = (r_count != '0) && dec_ready_i && !w_flush;

  assign w_outst_nxt = r_outst + OW'(w_gnt) - OW'(w_rsp);

  assign icache_req_o = w_req;
  assign icache_adr_o = w_req ? r_req_pc : '0;
  assign instr_v_q_o  = (r_count != '0);
  assign instr_q_o    = r_mem_instr[r_rptr];
  assign pc_q_o       = r_mem_pc[r_rptr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN, S_DRAIN: begin
        if (w_flush) begin
          w_state_nxt = (w_outst_nxt != '0) ? S_DRAIN : S_RUN;
        end else if ((r_state == S_DRAIN) && (w_outst_nxt == '0)) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_BOOT;
      r_req_pc <= '0;
      r_rsp_pc <= '0;
      r_outst  <= '0;
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_outst <= w_outst_nxt;
      if (r_state == S_BOOT) begin
        r_req_pc <= reset_adr_i;
        r_rsp_pc <= reset_adr_i;
      end else if (w_flush) begin
        r_req_pc <= pc_data_q_i;
        r_rsp_pc <= pc_data_q_i;
        r_count  <= '0;
        r_wptr   <= '0;
        r_rptr   <= '0;
      end else begin
        if (w_gnt) begin
          r_req_pc <= r_req_pc + XLEN'(4);
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
          r_wptr   <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Queue storage is cleared on reset so the head outputs read 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_mem_instr[r_wptr] <= icache_instr_i;
      r_mem_pc[r_wptr]    <= r_rsp_pc;
    end
  end

  a_no_push_full : assert property (@(posedge clk) disable iff (!reset_n)
    !(w_push && !w_pop && (r_count == CW'(DEPTH))));
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!reset_n)
    !(icache_rvalid_i && (r_outst == '0) && (r_state != S_BOOT)));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  localparam int XLEN      = 32;
  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic            clk;
  logic            reset_n;
  logic [XLEN-1:0] reset_adr_i;
  logic            icache_req_o;
  logic [XLEN-1:0] icache_adr_o;
  logic            icache_gnt_i;
  logic            icache_rvalid_i;
  logic [31:0]     icache_instr_i;
  logic            flush_v_i;
  logic [XLEN-1:0] pc_data_q_i;
  logic            dec_ready_i;
  logic            instr_v_q_o;
  logic [31:0]     instr_q_o;
  logic [XLEN-1:0] pc_q_o;

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset_n(reset_n), .reset_adr_i(reset_adr_i),
    .icache_req_o(icache_req_o), .icache_adr_o(icache_adr_o),
    .icache_gnt_i(icache_gnt_i), .icache_rvalid_i(icache_rvalid_i),
    .icache_instr_i(icache_instr_i), .flush_v_i(flush_v_i),
    .pc_data_q_i(pc_data_q_i), .dec_ready_i(dec_ready_i),
    .instr_v_q_o(instr_v_q_o), .instr_q_o(instr_q_o), .pc_q_o(pc_q_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // icache behaviour: granted addresses answered in order after a latency
  typedef struct { logic [31:0] adr; int rdy; } ic_t;
  ic_t ic_q[$];

  // reference model: queue contents seen by decode plus fetch bookkeeping
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  int          m_mode;      // 0 booting, 1 fetching, 2 draining after redirect
  logic [31:0] m_req_pc;
  logic [31:0] m_rsp_pc;
  int          m_outst;

  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        last_gnt;
  logic [31:0] last_adr;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic assert_reset(input logic [31:0] radr);
    @(negedge clk);
    reset_n = 1'b0;
    reset_adr_i = radr;
    icache_gnt_i = 1'b0;
    icache_rvalid_i = 1'b0;
    icache_instr_i = '0;
    flush_v_i = 1'b0;
    pc_data_q_i = '0;
    dec_ready_i = 1'b0;
    ic_q.delete();
    m_q.delete();
    m_mode = 0;
    m_outst = 0;
    m_req_pc = '0;
    m_rsp_pc = '0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance model.
  task automatic step(input logic flush, input logic [31:0] tgt, input logic rdy);
    logic        exp_req;
    logic [31:0] exp_adr;
    logic        rsp;
    logic        g;
    logic [31:0] rinstr;
    @(negedge clk);
    flush_v_i = flush;
    pc_data_q_i = tgt;
    dec_ready_i = rdy;
    g = (int'($urandom_range(99, 0)) < gnt_pct);
    icache_gnt_i = g;
    rsp = (ic_q.size() > 0) && (ic_q[0].rdy <= cyc);
    rinstr = rsp ? hash(ic_q[0].adr) : $urandom;
    icache_rvalid_i = rsp;
    icache_instr_i = rinstr;
    if (rsp) ic_q.delete(0);
    #1;
    exp_req = (m_mode == 1) && !flush && (m_q.size() + m_outst < DEPTH) && (m_outst < MAX_OUTST);
    exp_adr = exp_req ? m_req_pc : 32'h0;
    checks++;
    if (icache_req_o !== exp_req) begin
      failures++;
      $display("FAIL req cyc=%0d got=%b exp=%b", cyc, icache_req_o, exp_req);
    end
    checks++;
    if (icache_adr_o !== exp_adr) begin
      failures++;
      $display("FAIL adr cyc=%0d got=%h exp=%h", cyc, icache_adr_o, exp_adr);
    end
    checks++;
    if (instr_v_q_o !== (m_q.size() > 0)) begin
      failures++;
      $display("FAIL instr_v cyc=%0d got=%b exp=%b", cyc, instr_v_q_o, m_q.size() > 0);
    end
    if (m_q.size() > 0) begin
      checks++;
      if (pc_q_o !== m_q[0].pc) begin
        failures++;
        $display("FAIL pc_q cyc=%0d got=%h exp=%h", cyc, pc_q_o, m_q[0].pc);
      end
      checks++;
      if (instr_q_o !== m_q[0].instr) begin
        failures++;
        $display("FAIL instr_q cyc=%0d got=%h exp=%h", cyc, instr_q_o, m_q[0].instr);
      end
    end
    last_gnt = icache_req_o && g;
    last_adr = icache_adr_o;
    if (last_gnt) ic_q.push_back('{icache_adr_o, cyc + int'($urandom_range(lat_max, lat_min))});
    if (m_mode == 0) begin
      m_req_pc = reset_adr_i;
      m_rsp_pc = reset_adr_i;
      m_mode = 1;
    end else if (flush) begin
      if (rsp) m_outst--;
      m_q.delete();
      m_req_pc = tgt;
      m_rsp_pc = tgt;
      m_mode = (m_outst > 0) ? 2 : 1;
    end else if (m_mode == 1) begin
      if (m_q.size() > 0 && rdy) m_q.delete(0);
      if (rsp) begin
        m_q.push_back('{m_rsp_pc, rinstr});
        m_rsp_pc += 32'd4;
        m_outst--;
      end
      if (exp_req && g) begin
        m_req_pc += 32'd4;
        m_outst++;
      end
    end else begin
      if (rsp) m_outst--;
      if (m_outst == 0) m_mode = 1;
    end
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    assert_reset(32'h8000_0000);
    checks++;
    if ({icache_req_o, icache_adr_o, instr_v_q_o, instr_q_o, pc_q_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b adr=%h v=%b instr=%h pc=%h exp all 0",
               icache_req_o, icache_adr_o, instr_v_q_o, instr_q_o, pc_q_o);
    end
    release_reset();
  endtask

  task automatic test_boot();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (icache_req_o !== 1'b0) begin
      failures++;
      $display("FAIL boot_no_req got=%b exp=0", icache_req_o);
    end
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (icache_adr_o !== 32'h8000_0000) begin
      failures++;
      $display("FAIL boot_adr0 got=%h exp=80000000", icache_adr_o);
    end
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (icache_adr_o !== 32'h8000_0004) begin
      failures++;
      $display("FAIL boot_adr1 got=%h exp=80000004", icache_adr_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (!instr_v_q_o || pc_q_o !== 32'h8000_0000 + 32'(4 * i) ||
          instr_q_o !== hash(32'h8000_0000 + 32'(4 * i))) begin
        failures++;
        $display("FAIL boot_decode i=%0d got v=%b pc=%h instr=%h exp pc=%h",
                 i, instr_v_q_o, pc_q_o, instr_q_o, 32'h8000_0000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    int grants;
    int pops;
    logic resumed;
    assert_reset(32'h0000_2000);
    release_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    grants = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (last_gnt) grants++;
    end
    checks++;
    if (grants != DEPTH || icache_req_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_fill got grants=%0d req=%b exp grants=%0d req=0", grants, icache_req_o, DEPTH);
    end
    pops = 0;
    resumed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (last_gnt) resumed = 1'b1;
      if (instr_v_q_o && pops < DEPTH) begin
        checks++;
        if (pc_q_o !== 32'h2000 + 32'(4 * pops)) begin
          failures++;
          $display("FAIL bp_order n=%0d got=%h exp=%h", pops, pc_q_o, 32'h2000 + 32'(4 * pops));
        end
        pops++;
      end
    end
    checks++;
    if (pops != DEPTH || !resumed) begin
      failures++;
      $display("FAIL bp_release got pops=%0d resumed=%b exp pops=%0d resumed=1", pops, resumed, DEPTH);
    end
  endtask

  task automatic test_flush_outstanding();
    int n;
    logic seen;
    assert_reset(32'h0000_4000);
    release_reset();
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    n = 0;
    while (m_outst < 2 && n < 20) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
    end
    step(1'b1, 32'h0000_1000, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (instr_v_q_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty got v=%b exp=0", instr_v_q_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (last_gnt) begin
        seen = 1'b1;
        checks++;
        if (last_adr !== 32'h0000_1000) begin
          failures++;
          $display("FAIL flush_first_req got=%h exp=00001000", last_adr);
        end
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 32'h0, 1'b1);
      seen = instr_v_q_o;
    end
    checks++;
    if (!seen || pc_q_o !== 32'h0000_1000) begin
      failures++;
      $display("FAIL flush_first_pc got v=%b pc=%h exp pc=00001000", seen, pc_q_o);
    end
  endtask

  task automatic test_flush_coincident();
    logic hit;
    logic seen;
    assert_reset(32'h0000_6000);
    release_reset();
    gnt_pct = 100; lat_min = 2; lat_max = 2;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (ic_q.size() > 0 && ic_q[0].rdy <= cyc && m_q.size() > 0) begin
        hit = 1'b1;
        step(1'b1, 32'h0000_7000, 1'b1);
      end else begin
        step(1'b0, 32'h0, 1'b1);
      end
    end
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (!hit || instr_v_q_o !== 1'b0) begin
      failures++;
      $display("FAIL coinc_flush got hit=%b v=%b exp hit=1 v=0", hit, instr_v_q_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 32'h0, 1'b1);
      seen = instr_v_q_o;
    end
    checks++;
    if (!seen || pc_q_o !== 32'h0000_7000) begin
      failures++;
      $display("FAIL coinc_first_pc got v=%b pc=%h exp pc=00007000", seen, pc_q_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_adr [3];
    int k;
    exp_adr[0] = 32'hFFFF_FFF8;
    exp_adr[1] = 32'hFFFF_FFFC;
    exp_adr[2] = 32'h0000_0000;
    assert_reset(32'hFFFF_FFF8);
    release_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    k = 0;
    for (int i = 0; i < 10 && k < 3; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (last_gnt) begin
        checks++;
        if (last_adr !== exp_adr[k]) begin
          failures++;
          $display("FAIL wrap_adr n=%0d got=%h exp=%h", k, last_adr, exp_adr[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 3) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=3", k);
    end
  endtask

  task automatic test_back_to_back();
    assert_reset(32'h0000_9000);
    release_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (3) step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (instr_v_q_o !== 1'b1 || pc_q_o !== 32'h9000 + 32'(4 * i) || m_q.size() != 1) begin
        failures++;
        $display("FAIL b2b i=%0d got v=%b pc=%h occ=%0d exp v=1 pc=%h occ=1",
                 i, instr_v_q_o, pc_q_o, m_q.size(), 32'h9000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int r = 0; r < 3; r++) begin
      assert_reset({$urandom, 2'b00} >> 0);
      checks++;
      if (icache_req_o !== 1'b0 || instr_v_q_o !== 1'b0) begin
        failures++;
        $display("FAIL rand_reset got req=%b v=%b exp 0 0", icache_req_o, instr_v_q_o);
      end
      release_reset();
      gnt_pct = 60; lat_min = 1; lat_max = 4;
      for (int i = 0; i < 500; i++) begin
        tgt = {$urandom, 2'b00} >> 0;
        tgt[1:0] = 2'b00;
        step($urandom_range(99, 0) < 3, tgt, $urandom_range(99, 0) < 70);
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    reset_adr_i = '0;
    icache_gnt_i = 1'b0;
    icache_rvalid_i = 1'b0;
    icache_instr_i = '0;
    flush_v_i = 1'b0;
    pc_data_q_i = '0;
    dec_ready_i = 1'b0;
    test_reset();
    test_boot();
    test_backpressure();
    test_flush_outstanding();
    test_flush_coincident();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Parametrised successor to the single-register fetch stage. Issues sequential instruction requests to an icache with a req/gnt handshake and variable response latency. Buffers returned instructions with their PCs in a DEPTH-entry queue toward decode, which back-pressures via a ready signal. Handles EXE redirects (flush) by dropping queued entries and squashing in-flight responses.

Parameters:
XLEN, 32, address/PC width (matches riscv_pkg XLEN)
DEPTH, 4, instruction queue entries (power of two, >=2)
MAX_OUTST, 2, max icache requests granted but not yet answered (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
reset_adr_i  in  XLEN  boot PC, sampled first cycle after reset release
icache_req_o  out  1  fetch request valid
icache_adr_o  out  XLEN  fetch address, word aligned
icache_gnt_i  in  1  request accepted this cycle (only meaningful with req)
icache_rvalid_i  in  1  response valid, responses strictly in grant order, >=1 cycle after gnt
icache_instr_i  in  32  response instruction
flush_v_i  in  1  redirect from EXE
pc_data_q_i  in  XLEN  redirect target
dec_ready_i  in  1  decode accepts head entry this cycle
instr_v_q_o  out  1  head entry valid
instr_q_o  out  32  head instruction
pc_q_o  out  XLEN  head PC

Behaviour:
- Reset (async assert): state=BOOT, req_pc=0, rsp_pc=0, outst=0, queue empty; outputs icache_req_o=0, icache_adr_o=0, instr_v_q_o=0, instr_q_o=0, pc_q_o=0.
- FSM states BOOT, RUN, DRAIN.
- BOOT: one cycle after reset release; no request; req_pc<=reset_adr_i, rsp_pc<=reset_adr_i; ->RUN.
- RUN: icache_req_o=1 when occupancy+outst<DEPTH and outst<MAX_OUTST and !flush_v_i; icache_adr_o=req_pc (0 when req low). On req&gnt: req_pc<=req_pc+4 (mod 2^XLEN), outst++.
- Response in RUN: on rvalid push {rsp_pc, icache_instr_i}, rsp_pc<=rsp_pc+4, outst--. Credit rule guarantees no push when full; push while full is a bench assertion failure.
- Pop: when instr_v_q_o&dec_ready_i, head advances next cycle. Push and pop same cycle: occupancy unchanged, both take effect. Push into empty queue visible on outputs next cycle (1-cycle response-to-decode latency).
- Outputs instr_q_o/pc_q_o come from head register; undefined content not required when instr_v_q_o=0, but must be 0 after reset.
- Flush (any state except BOOT, highest priority): queue emptied (instr_v_q_o=0 next cycle), pop ignored, req_pc<=pc_data_q_i, rsp_pc<=pc_data_q_i, no request issued that cycle, rvalid that cycle discarded. Next state: DRAIN if outstanding after this cycle's discard >0, else RUN.
- DRAIN: icache_req_o=0; each rvalid discarded, outst--; ->RUN the cycle outst reaches 0. A flush in DRAIN reloads req_pc/rsp_pc and stays in DRAIN.
- flush_v_i during BOOT ignored.
- rvalid with outst=0: ignored, assertion.
- outst counter width clog2(MAX_OUTST+1); occupancy width clog2(DEPTH+1); pointers wrap mod DEPTH.
- Reset asserted mid-operation: immediate return to reset values; in-flight responses after release must not be pushed (bench keeps icache idle across reset).

Test Plan:
- Boot: reset_adr_i=0x80000000, gnt=1, 1-cycle latency -> BOOT one cycle, then icache_adr_o 0x80000000, 0x80000004...; decode sees pc_q_o 0x80000000 with its instruction, one per cycle.
- Back-pressure: dec_ready_i=0, DEPTH=4 -> exactly 4 entries filled, icache_req_o drops to 0, no further grants; release ready -> entries drain in order 0x..00..0x..0C, fetching resumes.
- Flush with 2 outstanding: flush_v_i=1, pc_data_q_i=0x1000 -> instr_v_q_o=0 next cycle, DRAIN discards 2 responses, then first request at 0x1000 and first decoded pc_q_o=0x1000.
- Flush coincident with rvalid and dec_ready_i -> response discarded, no pop credited, outst decremented once.
- Wrap: reset_adr_i=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Simultaneous push/pop at occupancy 1 for 10 cycles -> occupancy stays 1, PCs contiguous, no drops.
